// File: rtl/eth_crc_stream.sv
// Multi-lane streaming CRC engine (FCS generate / residue check); result strobes one clock after the last beat.
// s_ready drops only for the single DONE cycle between frames; mid-frame s_valid gaps simply hold state.
module eth_crc_stream #(
  parameter int                 CRC_LEN    = 32,
  parameter logic [CRC_LEN-1:0] POLY       = 32'h04C11DB7,
  parameter logic [CRC_LEN-1:0] INIT       = 32'hFFFFFFFF,
  parameter logic [CRC_LEN-1:0] XOR_OUT    = 32'hFFFFFFFF,
  parameter bit                 REFIN      = 1'b1,
  parameter bit                 REFOUT     = 1'b1,
  parameter int                 DATA_BYTES = 4,
  parameter logic [CRC_LEN-1:0] RESIDUE    = 32'hC704DD7B,
  parameter int                 LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  input  logic                    check_mode,
  output logic                    crc_valid,
  output logic [CRC_LEN-1:0]      crc_out,
  output logic                    crc_ok,
  output logic [LEN_W-1:0]        frame_len,
  output logic                    keep_err
);

  localparam int CNT_W = $clog2(DATA_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CRC_LEN-1:0] crc_q, crc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               mode_q, mode_d;
  logic [CRC_LEN-1:0] crc_out_q, crc_out_d;
  logic               crc_ok_q, crc_ok_d;
  logic [LEN_W-1:0]   frame_len_q, frame_len_d;
  logic               keep_err_q, keep_err_d;

  logic               accept;
  logic [CRC_LEN-1:0] crc_base;
  logic [CRC_LEN-1:0] crc_next;
  logic [LEN_W-1:0]   len_base;
  logic [LEN_W:0]     len_sum;
  logic [LEN_W-1:0]   len_next;
  logic [CNT_W-1:0]   lane_cnt;
  logic [DATA_BYTES-1:0] keep_inc;
  logic               keep_contig;
  logic               mode_eff;

  // One byte through the MSB-first register: optional input reflection, then 8 shift/XOR steps.
  function automatic logic [CRC_LEN-1:0] crc_byte(input logic [CRC_LEN-1:0] c_in,
                                                  input logic [7:0]         b_in);
    logic [CRC_LEN-1:0] c;
    logic [7:0]         b;
    b = b_in;
    if (REFIN) begin
      for (int i = 0; i < 8; i++) b[i] = b_in[7-i];
    end
    c = c_in;
    c[CRC_LEN-1 -: 8] = c[CRC_LEN-1 -: 8] ^ b;
    for (int k = 0; k < 8; k++) begin
      c = c[CRC_LEN-1] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [CRC_LEN-1:0] bit_rev(input logic [CRC_LEN-1:0] v);
    logic [CRC_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < CRC_LEN; i++) r[i] = v[CRC_LEN-1-i];
    return r;
  endfunction

  assign s_ready = !rst && (state_q != DONE);
  assign accept  = s_valid && s_ready;

  // Datapath for the beat currently offered; only committed when the beat is accepted.
  always_comb begin
    crc_base = (state_q == IDLE) ? INIT : crc_q;
    len_base = (state_q == IDLE) ? '0 : len_q;
    mode_eff = (state_q == IDLE) ? check_mode : mode_q;
    crc_next = crc_base;
    lane_cnt = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (!s_last || s_keep[i]) begin
        crc_next = crc_byte(crc_next, s_data[8*i +: 8]);
        lane_cnt = lane_cnt + CNT_W'(1);
      end
    end
    len_sum  = {1'b0, len_base} + (LEN_W+1)'(lane_cnt);
    len_next = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
    // A legal keep is 0..01..1: nonzero, and adding one clears every set bit.
    keep_inc    = s_keep + DATA_BYTES'(1);
    keep_contig = (s_keep != '0) && ((s_keep & keep_inc) == '0);
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    len_d       = len_q;
    mode_d      = mode_q;
    crc_out_d   = crc_out_q;
    crc_ok_d    = crc_ok_q;
    frame_len_d = frame_len_q;
    keep_err_d  = keep_err_q;

    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          if (state_q == IDLE) mode_d = check_mode;
          crc_d   = crc_next;
          len_d   = len_next;
          state_d = s_last ? DONE : ACC;
          if (s_last) begin
            crc_out_d   = (REFOUT ? bit_rev(crc_next) : crc_next) ^ XOR_OUT;
            crc_ok_d    = mode_eff && (crc_next == RESIDUE);
            frame_len_d = len_next;
            keep_err_d  = !keep_contig;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      len_q       <= '0;
      mode_q      <= 1'b0;
      crc_out_q   <= '0;
      crc_ok_q    <= 1'b0;
      frame_len_q <= '0;
      keep_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      crc_out_q   <= crc_out_d;
      crc_ok_q    <= crc_ok_d;
      frame_len_q <= frame_len_d;
      keep_err_q  <= keep_err_d;
    end
  end

  assign crc_valid = (state_q == DONE);
  assign crc_out   = crc_out_q;
  assign crc_ok    = crc_ok_q;
  assign frame_len = frame_len_q;
  assign keep_err  = keep_err_q;

endmodule

// File: tb/tb_eth_crc_stream.sv
// Scoreboarded bench for eth_crc_stream: directed Ethernet CRC vectors plus randomized frames vs a reflected-CRC model.
module tb_eth_crc_stream;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [31:0] crc;
    logic        ok;
    logic [15:0] len;
    logic        kerr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last;
  logic        check_mode;
  logic        crc_valid;
  logic [31:0] crc_out;
  logic        crc_ok;
  logic [15:0] frame_len;
  logic        keep_err;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  eth_crc_stream #(.DATA_BYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_keep     (s_keep),
    .s_last     (s_last),
    .check_mode (check_mode),
    .crc_valid  (crc_valid),
    .crc_out    (crc_out),
    .crc_ok     (crc_ok),
    .frame_len  (frame_len),
    .keep_err   (keep_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: LSB-first CRC-32 with the reflected polynomial; returns the register before final XOR.
  function automatic logic [31:0] ref_reg(input bq_t q);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    foreach (q[i]) begin
      r = r ^ {24'd0, q[i]};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic push_model(input bq_t q, input logic cm, input logic kerr);
    exp_t e;
    logic [31:0] r;
    r      = ref_reg(q);
    e.crc  = r ^ 32'hFFFFFFFF;
    e.ok   = cm && (r == 32'hDEBB20E3);
    e.len  = 16'(q.size());
    e.kerr = kerr;
    sb_q.push_back(e);
  endtask

  task automatic push_const(input logic [31:0] c, input logic ok, input logic [15:0] len,
                            input logic kerr);
    exp_t e;
    e.crc = c; e.ok = ok; e.len = len; e.kerr = kerr;
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           input logic cm, output int stalls);
    bit got;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l; check_mode = cm;
    stalls = 0;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      if (s_ready === 1'b1) got = 1'b1;
      else stalls++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: s_ready=%b, expected 1 within 64 cycles", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = $urandom; s_keep = 4'($urandom); s_last = 1'($urandom);
    check_mode = 1'($urandom);
    if (l) chk("latency_crc_valid", 32'(crc_valid), 32'd1);
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input bq_t q, input logic cm, input int gap_pct,
                            output int first_stalls);
    int          n, i, take, st;
    logic [31:0] d;
    logic [3:0]  k;
    n = q.size(); i = 0; first_stalls = 0;
    while (i < n) begin
      take = (n - i >= 4) ? 4 : n - i;
      d = $urandom;
      for (int j = 0; j < take; j++) d[8*j +: 8] = q[i+j];
      k = 4'((1 << take) - 1);
      if (i > 0 && $urandom_range(99) < gap_pct) idle_cycle();
      send_beat(d, k, (i + take == n), cm, st);
      if (i == 0) first_stalls = st;
      i += take;
    end
  endtask

  always @(negedge clk) begin
    if (crc_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_crc_valid: crc_out=%h with no frame outstanding", crc_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("crc_out", crc_out, mon_e.crc);
        chk("crc_ok", 32'(crc_ok), 32'(mon_e.ok));
        chk("frame_len", 32'(frame_len), 32'(mon_e.len));
        chk("keep_err", 32'(keep_err), 32'(mon_e.kerr));
        chk("ready_in_done", 32'(s_ready), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    int  st;
    logic [31:0] fcs;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; check_mode = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_crc_valid", 32'(crc_valid), 32'd0);
    chk("rst_crc_out", crc_out, 32'd0);
    chk("rst_crc_ok", 32'(crc_ok), 32'd0);
    chk("rst_frame_len", 32'(frame_len), 32'd0);
    chk("rst_keep_err", 32'(keep_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;

    // Standard check value.
    push_const(32'hCBF43926, 1'b0, 16'd9, 1'b0);
    send_frame(str2q("123456789"), 1'b0, 0, st);

    // Check mode: payload plus its FCS leaves the good-frame residue.
    q = str2q("123456789");
    q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
    push_const(32'h2144DF1C, 1'b1, 16'd13, 1'b0);
    send_frame(q, 1'b1, 0, st);

    q[2] = q[2] ^ 8'h10;
    push_model(q, 1'b1, 1'b0);
    chk("model_flip_not_ok", 32'(sb_q[sb_q.size()-1].ok), 32'd0);
    send_frame(q, 1'b1, 0, st);

    // Single zero byte, immediately followed by a second frame.
    q = {};
    q.push_back(8'h00);
    push_const(32'hD202EF8D, 1'b0, 16'd1, 1'b0);
    send_frame(q, 1'b0, 0, st);
    push_const(32'hCBF43926, 1'b0, 16'd9, 1'b0);
    send_frame(str2q("123456789"), 1'b0, 0, st);
    chk("b2b_bubble_cycles", 32'(st), 32'd1);

    // Valid toggling every other cycle mid-frame.
    push_const(32'hCBF43926, 1'b0, 16'd9, 1'b0);
    send_frame(str2q("123456789"), 1'b0, 100, st);

    // Non-contiguous keep: lanes 0 and 2 of the last beat still processed.
    q = str2q("12345");
    q.push_back("7");
    push_model(q, 1'b0, 1'b1);
    send_beat(32'h34333231, 4'hF, 1'b0, 1'b0, st);
    send_beat(32'h38373635, 4'b0101, 1'b1, 1'b0, st);

    // All-zero keep on the last beat.
    push_const(32'h9AE0DAAF, 1'b0, 16'd8, 1'b1);
    send_beat(32'h34333231, 4'hF, 1'b0, 1'b0, st);
    send_beat(32'h38373635, 4'hF, 1'b0, 1'b0, st);
    send_beat(32'hDEADBEEF, 4'b0000, 1'b1, 1'b0, st);

    // Reset mid-frame aborts without a result.
    send_beat(32'h34333231, 4'hF, 1'b0, 1'b0, st);
    send_beat(32'h38373635, 4'hF, 1'b0, 1'b0, st);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_crc_valid", 32'(crc_valid), 32'd0);
    chk("midrst_crc_out", crc_out, 32'd0);
    chk("midrst_crc_ok", 32'(crc_ok), 32'd0);
    chk("midrst_frame_len", 32'(frame_len), 32'd0);
    chk("midrst_keep_err", 32'(keep_err), 32'd0);
    idle_cycle(); idle_cycle();
    push_const(32'hCBF43926, 1'b0, 16'd9, 1'b0);
    send_frame(str2q("123456789"), 1'b0, 0, st);

    // Randomized frames, some in check mode with a correct or corrupted FCS.
    for (int f = 0; f < 40; f++) begin
      logic cm;
      q = {};
      for (int b = 0, n = $urandom_range(40, 1); b < n; b++) q.push_back(8'($urandom));
      cm = 1'($urandom);
      if (cm && $urandom_range(1) == 1) begin
        fcs = ref_reg(q) ^ 32'hFFFFFFFF;
        for (int b = 0; b < 4; b++) q.push_back(fcs[8*b +: 8]);
        if ($urandom_range(3) == 0) q[0] = q[0] ^ 8'h01;
      end
      push_model(q, cm, 1'b0);
      send_frame(q, cm, $urandom_range(50), st);
      if ($urandom_range(1) == 1) idle_cycle();
    end

    for (int c = 0; c < 4; c++) idle_cycle();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
